// File: rtl/sol1_fpu.sv
// Byte-wide IEEE-754 single-precision add/sub/mul coprocessor for the Sol-1 CPU bus.
// cmd_end rises at most ~31 clocks after the opcode write; new writes are dropped until end_ack.
module sol1_fpu (
   input  logic       clk,
   input  logic       arst,
   input  logic [7:0] databus_in,
   output logic [7:0] databus_out,
   input  logic [3:0] addr,
   input  logic       cs,
   input  logic       rd,
   input  logic       wr,
   input  logic       end_ack,
   output logic       cmd_end,
   output logic       busy
);
   typedef enum logic [3:0] {
      S_IDLE, S_UNPACK, S_ADD_ALIGN, S_ADD_SUM, S_MUL,
      S_NORMALIZE, S_ROUND, S_PACK, S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        a_q, a_d, b_q, b_d, result_q, result_d;
   logic [7:0]         op_q, op_d;
   logic               wr_q;
   logic               sa_q, sa_d, sb_q, sb_d, sign_q, sign_d;
   logic [7:0]         ea_q, ea_d, eb_q, eb_d;
   logic [23:0]        ma_q, ma_d, mb_q, mb_d;
   logic signed [10:0] exp_q, exp_d;
   logic [27:0]        man_q, man_d;
   logic [26:0]        aux_q, aux_d;
   logic               spec_q, spec_d;
   logic [31:0]        spec_val_q, spec_val_d;

   logic        wr_commit, start, op_valid;
   logic        nan_in, mul_zero, unpack_special;
   logic        a_ge_b, big_s;
   logic [23:0] big_m, small_m;
   logic [7:0]  big_e, small_e, diff;
   logic [26:0] small_ext, small_sh, aligned;
   logic        small_sticky;
   logic [47:0] prod;
   logic        round_up;
   logic [24:0] m25;
   logic [31:0] pack_val;

   assign wr_commit      = !cs && !wr && wr_q && (state_q == S_IDLE);
   assign start          = wr_commit && (addr == 4'h8);
   assign op_valid       = (databus_in <= 8'h02);
   assign nan_in         = (a_q[30:23] == 8'hFF) || (b_q[30:23] == 8'hFF);
   assign mul_zero       = (op_q == 8'h02) && ((a_q[30:23] == 8'h00) || (b_q[30:23] == 8'h00));
   assign unpack_special = nan_in || mul_zero;
   assign prod           = {24'h0, ma_q} * {24'h0, mb_q};

   // Alignment: larger magnitude stays put, smaller one shifts right keeping G/R/S.
   always_comb begin
      a_ge_b    = ({ea_q, ma_q} >= {eb_q, mb_q});
      big_m     = a_ge_b ? ma_q : mb_q;
      small_m   = a_ge_b ? mb_q : ma_q;
      big_e     = a_ge_b ? ea_q : eb_q;
      small_e   = a_ge_b ? eb_q : ea_q;
      big_s     = a_ge_b ? sa_q : sb_q;
      diff      = big_e - small_e;
      small_ext = {small_m, 3'b000};
      if (diff >= 8'd27) begin
         small_sh     = 27'h0;
         small_sticky = |small_m;
      end else begin
         small_sh     = small_ext >> diff;
         small_sticky = |(small_ext & ~(27'h7FF_FFFF << diff));
      end
      aligned = {small_sh[26:1], small_sh[0] | small_sticky};
   end

   always_comb begin
      round_up = man_q[2] & (man_q[1] | man_q[0] | man_q[3]);
      m25      = {1'b0, man_q[26:3]} + {24'h0, round_up};
   end

   always_comb begin
      if (spec_q)                pack_val = spec_val_q;
      else if (!man_q[26])       pack_val = 32'h0000_0000;
      else if (exp_q >= 11'sd255) pack_val = {sign_q, 8'hFF, 23'h0};
      else if (exp_q <= 11'sd0)  pack_val = 32'h0000_0000;
      else                       pack_val = {sign_q, exp_q[7:0], man_q[25:3]};
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:      if (start) state_d = op_valid ? S_UNPACK : S_PACK;
         S_UNPACK: begin
            if (unpack_special)      state_d = S_PACK;
            else if (op_q == 8'h02)  state_d = S_MUL;
            else                     state_d = S_ADD_ALIGN;
         end
         S_ADD_ALIGN: state_d = S_ADD_SUM;
         S_ADD_SUM:   state_d = S_NORMALIZE;
         S_MUL:       state_d = S_NORMALIZE;
         S_NORMALIZE: if ((man_q == 28'h0) || (!man_q[27] && man_q[26])) state_d = S_ROUND;
         S_ROUND:     state_d = S_PACK;
         S_PACK:      state_d = S_DONE;
         S_DONE:      if (end_ack) state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy    = (state_q != S_IDLE) && (state_q != S_DONE);
      cmd_end = (state_q == S_DONE);
   end

   always_comb begin
      a_d = a_q; b_d = b_q; op_d = op_q; result_d = result_q;
      sa_d = sa_q; sb_d = sb_q; ea_d = ea_q; eb_d = eb_q; ma_d = ma_q; mb_d = mb_q;
      sign_d = sign_q; exp_d = exp_q; man_d = man_q; aux_d = aux_q;
      spec_d = spec_q; spec_val_d = spec_val_q;
      if (wr_commit) begin
         case (addr)
            4'h0: a_d[7:0]   = databus_in;
            4'h1: a_d[15:8]  = databus_in;
            4'h2: a_d[23:16] = databus_in;
            4'h3: a_d[31:24] = databus_in;
            4'h4: b_d[7:0]   = databus_in;
            4'h5: b_d[15:8]  = databus_in;
            4'h6: b_d[23:16] = databus_in;
            4'h7: b_d[31:24] = databus_in;
            4'h8: op_d       = databus_in;
            default: ;
         endcase
      end
      unique case (state_q)
         S_IDLE: if (start) begin
            spec_d     = !op_valid;
            spec_val_d = 32'h0000_0000;
         end
         S_UNPACK: begin
            sa_d = a_q[31];
            sb_d = b_q[31] ^ (op_q == 8'h01);
            ea_d = a_q[30:23];
            eb_d = b_q[30:23];
            ma_d = (a_q[30:23] != 8'h00) ? {1'b1, a_q[22:0]} : 24'h0;
            mb_d = (b_q[30:23] != 8'h00) ? {1'b1, b_q[22:0]} : 24'h0;
            if (nan_in) begin
               spec_d     = 1'b1;
               spec_val_d = 32'h7FC0_0000;
            end else if (mul_zero) begin
               spec_d     = 1'b1;
               spec_val_d = {a_q[31] ^ b_q[31], 31'h0};
            end
         end
         S_ADD_ALIGN: begin
            sign_d = big_s;
            exp_d  = $signed({3'b000, big_e});
            man_d  = {1'b0, big_m, 3'b000};
            aux_d  = aligned;
         end
         S_ADD_SUM: begin
            if (sa_q ^ sb_q) man_d = {1'b0, man_q[26:0]} - {1'b0, aux_q};
            else             man_d = {1'b0, man_q[26:0]} + {1'b0, aux_q};
         end
         S_MUL: begin
            sign_d = sa_q ^ sb_q;
            exp_d  = $signed({3'b000, ea_q}) + $signed({3'b000, eb_q}) - 11'sd127;
            man_d  = {prod[47:23], prod[22], prod[21], |prod[20:0]};
         end
         S_NORMALIZE: if (man_q != 28'h0) begin
            if (man_q[27]) begin
               man_d = {1'b0, man_q[27:2], man_q[1] | man_q[0]};
               exp_d = exp_q + 11'sd1;
            end else if (!man_q[26]) begin
               man_d = {man_q[26:0], 1'b0};
               exp_d = exp_q - 11'sd1;
            end
         end
         S_ROUND: begin
            if (m25[24]) begin
               man_d = {1'b0, m25[24:1], 3'b000};
               exp_d = exp_q + 11'sd1;
            end else begin
               man_d = {1'b0, m25[23:0], 3'b000};
            end
         end
         S_PACK:  result_d = pack_val;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         a_q <= '0; b_q <= '0; op_q <= '0; result_q <= '0; wr_q <= 1'b1;
         sa_q <= 1'b0; sb_q <= 1'b0; ea_q <= '0; eb_q <= '0; ma_q <= '0; mb_q <= '0;
         sign_q <= 1'b0; exp_q <= '0; man_q <= '0; aux_q <= '0;
         spec_q <= 1'b0; spec_val_q <= '0;
      end else begin
         a_q <= a_d; b_q <= b_d; op_q <= op_d; result_q <= result_d; wr_q <= wr;
         sa_q <= sa_d; sb_q <= sb_d; ea_q <= ea_d; eb_q <= eb_d; ma_q <= ma_d; mb_q <= mb_d;
         sign_q <= sign_d; exp_q <= exp_d; man_q <= man_d; aux_q <= aux_d;
         spec_q <= spec_d; spec_val_q <= spec_val_d;
      end
   end

   always_comb begin
      databus_out = 8'h00;
      if (!cs && !rd) begin
         case (addr)
            4'h9:    databus_out = result_q[7:0];
            4'hA:    databus_out = result_q[15:8];
            4'hB:    databus_out = result_q[23:16];
            4'hC:    databus_out = result_q[31:24];
            default: databus_out = 8'h00;
         endcase
      end
   end
endmodule

// File: tb/tb_sol1_fpu.sv
// Directed bench for sol1_fpu: bus-level operand/opcode writes, IRQ handshake, result readback.
module tb_sol1_fpu;
   logic       clk = 1'b0;
   logic       arst, cs, rd, wr, end_ack;
   logic [7:0] databus_in, databus_out;
   logic [3:0] addr;
   logic       cmd_end, busy;
   int         tests = 0;
   int         fails = 0;

   sol1_fpu dut (
      .clk(clk), .arst(arst), .databus_in(databus_in), .databus_out(databus_out),
      .addr(addr), .cs(cs), .rd(rd), .wr(wr), .end_ack(end_ack),
      .cmd_end(cmd_end), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      addr = a; databus_in = d; cs = 1'b0; wr = 1'b0;
      @(negedge clk);
      wr = 1'b1; cs = 1'b1;
   endtask

   task automatic write32(input logic [3:0] base, input logic [31:0] v);
      for (int i = 0; i < 4; i++) bus_write(base + 4'(i), v[8*i +: 8]);
   endtask

   task automatic read32(output logic [31:0] v);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         addr = 4'h9 + 4'(i); cs = 1'b0; rd = 1'b0;
         #1 v[8*i +: 8] = databus_out;
         rd = 1'b1; cs = 1'b1;
      end
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!cmd_end && n < 60) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic ack(input string tag);
      @(negedge clk); end_ack = 1'b1;
      @(negedge clk); end_ack = 1'b0;
      check({tag, "_ack_cmd_end"}, {31'd0, cmd_end}, 32'd0);
      check({tag, "_ack_busy"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [7:0] op, input logic [31:0] exp);
      int          n;
      logic [31:0] r;
      write32(4'h0, a);
      write32(4'h4, b);
      bus_write(4'h8, op);
      wait_done(n);
      check({tag, "_latency_ok"}, {31'd0, (cmd_end === 1'b1) && (n <= 40)}, 32'd1);
      read32(r);
      check(tag, r, exp);
   endtask

   initial begin
      int          n;
      logic [31:0] r;
      logic [7:0]  b8;
      arst = 1'b0; cs = 1'b1; rd = 1'b1; wr = 1'b1; end_ack = 1'b0;
      addr = 4'h0; databus_in = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_cmd_end", {31'd0, cmd_end}, 32'd0);
      arst = 1'b1;
      read32(r);
      check("reset_result", r, 32'h0000_0000);

      // Stray acknowledge while idle.
      @(negedge clk); end_ack = 1'b1;
      @(negedge clk); end_ack = 1'b0;
      check("idle_ack_cmd_end", {31'd0, cmd_end}, 32'd0);

      run_op("mul_2x3", 32'h4000_0000, 32'h4040_0000, 8'h02, 32'h40C0_0000);
      bus_write(4'h3, 8'h41);
      check("done_hold_cmd_end", {31'd0, cmd_end}, 32'd1);
      read32(r);
      check("done_result_held", r, 32'h40C0_0000);
      ack("mul_2x3");

      // Rerun without touching operands; opcode and operand writes during busy are dropped.
      bus_write(4'h8, 8'h02);
      check("rerun_busy", {31'd0, busy}, 32'd1);
      bus_write(4'h8, 8'h00);
      bus_write(4'h3, 8'h41);
      wait_done(n);
      check("rerun_done", {31'd0, cmd_end}, 32'd1);
      read32(r);
      check("rerun_ignored_writes", r, 32'h40C0_0000);
      ack("rerun");

      run_op("add_1p5_2p5", 32'h3FC0_0000, 32'h4020_0000, 8'h00, 32'h4080_0000);
      ack("add");
      run_op("sub_1_1", 32'h3F80_0000, 32'h3F80_0000, 8'h01, 32'h0000_0000);
      ack("sub");
      run_op("add_mixed", 32'h43A9_AB64, 32'hC479_FFF0, 8'h00, 32'hC425_2A3E);
      ack("add_mixed");
      run_op("mul_square", 32'h43A9_AB64, 32'h43A9_AB64, 8'h02, 32'h47E0_E77A);
      ack("mul_square");
      run_op("nan_in", 32'h7F80_0000, 32'h3F80_0000, 8'h00, 32'h7FC0_0000);
      ack("nan");
      run_op("mul_neg_zero", 32'h8000_0000, 32'h4000_0000, 8'h02, 32'h8000_0000);
      ack("mul_zero");

      // Asynchronous reset in the middle of a multiply.
      write32(4'h0, 32'h4000_0000);
      write32(4'h4, 32'h4040_0000);
      bus_write(4'h8, 8'h02);
      check("pre_rst_busy", {31'd0, busy}, 32'd1);
      #2 arst = 1'b0;
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_cmd_end", {31'd0, cmd_end}, 32'd0);
      addr = 4'hC; cs = 1'b0; rd = 1'b0;
      #1 b8 = databus_out;
      cs = 1'b1; rd = 1'b1;
      check("rst_dbus", {24'd0, b8}, 32'd0);
      @(negedge clk); arst = 1'b1;
      read32(r);
      check("rst_result", r, 32'h0000_0000);
      bus_write(4'h8, 8'h00);
      wait_done(n);
      read32(r);
      check("rst_operands_zero", r, 32'h0000_0000);
      ack("rst_add");

      run_op("mul_overflow", 32'h7F00_0000, 32'h4000_0000, 8'h02, 32'h7F80_0000);
      ack("overflow");

      bus_write(4'h8, 8'h05);
      wait_done(n);
      check("bad_op_latency_ok", {31'd0, (cmd_end === 1'b1) && (n <= 2)}, 32'd1);
      read32(r);
      check("bad_op_result", r, 32'h0000_0000);
      ack("bad_op");

      @(negedge clk);
      addr = 4'hD; cs = 1'b0; rd = 1'b0;
      #1 b8 = databus_out;
      cs = 1'b1; rd = 1'b1;
      check("reserved_read", {24'd0, b8}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/sol1_fpu.md
Name: sol1_fpu

Overview:
- Byte-wide, memory-mapped IEEE-754 single-precision coprocessor for the Sol-1 CPU bus.
- The CPU writes two 32-bit operands byte by byte, then writes an opcode to start an operation.
- The block computes in a multi-cycle FSM, raises cmd_end (IRQ) when done, holds the result for byte reads, and clears cmd_end on end_ack.

Parameters:
- None. Opcode encoding is fixed: 0x00 add, 0x01 sub, 0x02 mul.

Ports:
- clk  in  1  system clock. Interface: one clock; reset is asynchronous and active-low.
- arst  in  1  asynchronous reset, active-low.
- databus_in  in  8  write data.
- databus_out  out  8  read data.
- addr  in  4  register select.
- cs  in  1  chip select, active-low.
- rd  in  1  read strobe, active-low.
- wr  in  1  write strobe, active-low.
- end_ack  in  1  CPU acknowledge of cmd_end, active-high.
- cmd_end  out  1  operation complete / interrupt, active-high.
- busy  out  1  operation in progress, active-high.

Behaviour:
- Register map (little-endian bytes):
  - 0x0-0x3: operand A [7:0]..[31:24], write-only.
  - 0x4-0x7: operand B [7:0]..[31:24], write-only.
  - 0x8: opcode; writing it starts an operation.
  - 0x9-0xC: result [7:0]..[31:24], read-only.
  - 0xD-0xF: reserved; reads return 0x00, writes are ignored.
- Writes:
  - wr is registered as wr_q. A write commits on the rising clk where cs=0, wr=0 and wr_q=1: exactly one commit per wr low pulse.
  - A wr pulse lasting one full clock or longer must register.
  - Operand and opcode writes are ignored while busy=1 or cmd_end=1.
- Reads: databus_out = selected register when cs=0 and rd=0. It is combinational from addr, otherwise 0x00.
- Start: an opcode commit sets busy=1 on the same edge. The FSM leaves IDLE for the opcode's state.
- FSM states:
  - IDLE.
  - UNPACK: split sign, exponent and mantissa; hidden bit is 1 when exp≠0.
  - ADD_ALIGN: swap so |A|≥|B|, shift smaller mantissa right by the exponent difference, collecting guard/round/sticky.
  - ADD_SUM: add or subtract magnitudes. For sub, invert B's sign first.
  - MUL: 24x24 product; exponent = eA+eB−127.
  - NORMALIZE: shift left or right one bit per cycle until bit 23 is leading; stop at zero mantissa.
  - ROUND: round-to-nearest-even using G/R/S; renormalize on mantissa carry-out.
  - PACK.
  - DONE.
- Completion latency: opcode commit to cmd_end rise ≤ 40 clocks.
- On entering DONE:
  - result register loads; busy=0 and cmd_end=1 on the same edge.
  - cmd_end stays high until end_ack=1 is sampled, then clears next edge and the FSM returns to IDLE.
  - end_ack while cmd_end=0 has no effect.
- Special cases:
  - Denormal inputs are flushed to zero.
  - Exponent overflow gives ±infinity (0x7F800000 | sign).
  - Underflow gives +0.
  - Any operand with exp=0xFF gives NaN 0x7FC00000.
  - Exact zero sum gives +0.
  - Zero times anything finite gives zero with sign = sA^sB.
- Invalid opcode (>0x02): result = 0x00000000, DONE reached within 2 clocks.
- Reset (arst=0, any time, including mid-operation): operands, result and opcode are 0; FSM goes to IDLE; busy=0; cmd_end=0; databus_out=0x00.
- Result register holds its value until the next operation completes. Operands persist across operations.

Test Plan:
- Write A=0x40000000 (2.0), B=0x40400000 (3.0), opcode 0x02 → cmd_end rises ≤ 40 clocks; bytes 0x9..0xC read 00 00 C0 40 (0x40C00000); end_ack → cmd_end falls, busy=0.
- A=0x3FC00000 (1.5), B=0x40200000 (2.5), opcode 0x00 → result 0x40800000.
- A=0x3F800000, B=0x3F800000, opcode 0x01 → result 0x00000000.
- A=0x43A9AB64, B=0xC479FFF0, opcode 0x00 → result matches a reference IEEE round-to-nearest-even model (≈ −660.66); opcode 0x02 with A=B=0x43A9AB64 → result matches model (≈115151.0).
- Write opcode while busy, and operand while cmd_end=1 → both ignored; result unchanged.
- Assert arst mid-multiply → busy=0, cmd_end=0, result reads 0x00000000; A=0x7F000000 times B=0x40000000 → 0x7F800000.
